// File: rtl/vga_frame_buffer_db.sv
// ---------------------------------------------------------------------------
// vga_frame_buffer_db
//
// Double-buffered frame buffer between the PPU pixel writer and the VGA
// scan-out. The PPU always writes the back bank and the VGA always reads the
// front bank. The banks swap only during VGA vertical blanking, and only after
// the PPU has reported a finished frame, so a displayed frame never tears.
//
// The display window can be placed anywhere on the VGA raster through
// H_OFFSET / V_OFFSET. Outside that window the output is BLANK_PIX. The read
// path is registered and has exactly one cycle of latency. If the PPU finishes
// a frame while an earlier one is still waiting for vblank, the drop counter
// records it.
//
// Optional feature (compile-time macro FB_SCALE2X_EN):
//   When defined, the window is 2*FB_WIDTH x 2*FB_HEIGHT and every stored
//   pixel is shown as a 2x2 block. The latency stays at one cycle.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   ppu_row/col    PPU write coordinates (9 bits each)
//   ppu_data       PPU write pixel (PIX_W bits)
//   ppu_write_en   PPU write strobe
//   ppu_frame_done 1-cycle pulse: PPU finished a frame
//   vga_row/col    VGA scan coordinates (10 bits each)
//   vga_vblank     high during VGA vertical blanking
//   vga_data       pixel for the VGA coordinates of the previous cycle
//   swap_pending   a finished frame is waiting for vblank
//   front_sel      bank currently displayed
//   drop_count     saturating count of frames overwritten before display
// ---------------------------------------------------------------------------
module vga_frame_buffer_db #(
    parameter int               FB_WIDTH  = 256,
    parameter int               FB_HEIGHT = 240,
    parameter int               PIX_W     = 8,
    parameter logic [PIX_W-1:0] BLANK_PIX = PIX_W'(8'h3F),
    parameter int               H_OFFSET  = 0,
    parameter int               V_OFFSET  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [8:0]       ppu_row,
    input  logic [8:0]       ppu_col,
    input  logic [PIX_W-1:0] ppu_data,
    input  logic             ppu_write_en,
    input  logic             ppu_frame_done,
    input  logic [9:0]       vga_row,
    input  logic [9:0]       vga_col,
    input  logic             vga_vblank,
    output logic [PIX_W-1:0] vga_data,
    output logic             swap_pending,
    output logic             front_sel,
    output logic [7:0]       drop_count
);

    localparam int DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W = $clog2(DEPTH);

`ifdef FB_SCALE2X_EN
    localparam int SCALE_SHIFT = 1;
`else
    localparam int SCALE_SHIFT = 0;
`endif

    localparam int          WIN_W = FB_WIDTH  << SCALE_SHIFT;
    localparam int          WIN_H = FB_HEIGHT << SCALE_SHIFT;
    localparam logic [31:0] H_LO  = 32'(H_OFFSET);
    localparam logic [31:0] H_HI  = 32'(H_OFFSET + WIN_W);
    localparam logic [31:0] V_LO  = 32'(V_OFFSET);
    localparam logic [31:0] V_HI  = 32'(V_OFFSET + WIN_H);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [PIX_W-1:0] bank0 [DEPTH];
    logic [PIX_W-1:0] bank1 [DEPTH];

    logic [0:0]        state;
    logic              wr_ok;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       vrow_ext;
    logic [31:0]       vcol_ext;
    logic [31:0]       loc_row;
    logic [31:0]       loc_col;
    logic              in_window;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              in_window_q;

    // Write address decode. Out-of-range coordinates are rejected before
    // the address is formed, so they cannot alias onto any stored pixel.
    always_comb begin
        wr_ok   = ppu_write_en
                  && (32'(ppu_row) < 32'(FB_HEIGHT))
                  && (32'(ppu_col) < 32'(FB_WIDTH));
        wr_addr = ADDR_W'(ppu_row) * ADDR_W'(FB_WIDTH) + ADDR_W'(ppu_col);
    end

    // Window test and local coordinates. With pixel doubling, the local
    // coordinates are halved so each stored pixel covers a 2x2 block.
    // Outside the window the address is forced to 0 so the RAM is never
    // indexed past its depth.
    always_comb begin
        vrow_ext  = 32'(vga_row);
        vcol_ext  = 32'(vga_col);
        in_window = (vrow_ext >= V_LO) && (vrow_ext < V_HI)
                    && (vcol_ext >= H_LO) && (vcol_ext < H_HI);
        loc_row   = (vrow_ext - V_LO) >> SCALE_SHIFT;
        loc_col   = (vcol_ext - H_LO) >> SCALE_SHIFT;
        rd_addr   = in_window
                    ? (ADDR_W'(loc_row) * ADDR_W'(FB_WIDTH) + ADDR_W'(loc_col))
                    : '0;
    end

    // The back bank is the one not being displayed. front_sel is the value
    // in the write cycle, so a write on the swap edge still lands in the old
    // back bank, which has just become the front bank.
    always_ff @(posedge clk) begin
        if (wr_ok && front_sel) begin
            bank0[wr_addr] <= ppu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !front_sel) begin
            bank1[wr_addr] <= ppu_data;
        end
    end

    // Registered read from the front bank. The data register has no reset
    // because it mirrors RAM. Blanking at reset comes from the window flag.
    always_ff @(posedge clk) begin
        rd_data <= front_sel ? bank1[rd_addr] : bank0[rd_addr];
    end

    // The in-window flag travels with the read data. It has an async reset,
    // so vga_data shows BLANK_PIX as soon as rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_window_q <= 1'b0;
        end else begin
            in_window_q <= in_window;
        end
    end

    assign vga_data = in_window_q ? rd_data : BLANK_PIX;

    // Swap FSM. A finished frame waits in PENDING until vblank, and the
    // banks flip on that edge. Another frame_done while PENDING overwrites
    // the waiting frame, so it counts as a drop.
    // Known limitation: if frame_done and vblank arrive in the same PENDING
    // cycle, the swap wins. The new frame_done is lost and no drop is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            front_sel  <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ppu_frame_done) begin
                        state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (vga_vblank) begin
                        front_sel <= ~front_sel;
                        state     <= ST_IDLE;
                    end else if (ppu_frame_done && (drop_count != 8'hFF)) begin
                        drop_count <= drop_count + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign swap_pending = (state == ST_PENDING);

endmodule

// File: tb/tb_vga_frame_buffer_db.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_buffer_db
//
// Scoreboard bench for vga_frame_buffer_db. The window is placed at
// H_OFFSET=64. Stimulus pushes the expected DUT response into a queue,
// tagged with the cycle in which that response should appear. A separate
// monitor samples on the falling clock edge, pops due entries and compares
// them. Async-reset values are checked directly because no clock edge is
// involved. Coordinates for the doubled window are selected with
// FB_SCALE2X_EN.
// ---------------------------------------------------------------------------
module tb_vga_frame_buffer_db;

    localparam int HOFF = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [8:0] ppu_row = '0;
    logic [8:0] ppu_col = '0;
    logic [7:0] ppu_data = '0;
    logic       ppu_write_en = 1'b0;
    logic       ppu_frame_done = 1'b0;
    logic [9:0] vga_row = '0;
    logic [9:0] vga_col = '0;
    logic       vga_vblank = 1'b0;
    logic [7:0] vga_data;
    logic       swap_pending;
    logic       front_sel;
    logic [7:0] drop_count;

    vga_frame_buffer_db #(.H_OFFSET(HOFF)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ppu_row        (ppu_row),
        .ppu_col        (ppu_col),
        .ppu_data       (ppu_data),
        .ppu_write_en   (ppu_write_en),
        .ppu_frame_done (ppu_frame_done),
        .vga_row        (vga_row),
        .vga_col        (vga_col),
        .vga_vblank     (vga_vblank),
        .vga_data       (vga_data),
        .swap_pending   (swap_pending),
        .front_sel      (front_sel),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Signal selectors for scoreboard entries
    localparam int SIG_DATA = 0;
    localparam int SIG_FRONT = 1;
    localparam int SIG_PEND = 2;
    localparam int SIG_DROP = 3;

    typedef struct {
        string      name;
        int         sig;
        logic [7:0] exp;
        int         due;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sample(input int sig);
        case (sig)
            SIG_DATA:  return vga_data;
            SIG_FRONT: return {7'd0, front_sel};
            SIG_PEND:  return {7'd0, swap_pending};
            default:   return drop_count;
        endcase
    endfunction

    // The monitor pops every entry that is due in this cycle
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput(e.name, sample(e.sig), e.exp);
            end
        end
    end

    // Queue an expectation for the output that follows the next clock edge
    task automatic expectNext(input string name, input int sig,
                              input logic [7:0] exp);
        sb.push_back('{name, sig, exp, cyc + 1});
    endtask

    // Drive all inputs for one cycle, then move to just after the edge
    task automatic applyStimulus(input logic we, input logic [8:0] prow,
                                 input logic [8:0] pcol, input logic [7:0] pdata,
                                 input logic done, input logic vb,
                                 input logic [9:0] vrow, input logic [9:0] vcol);
        ppu_write_en   = we;
        ppu_row        = prow;
        ppu_col        = pcol;
        ppu_data       = pdata;
        ppu_frame_done = done;
        vga_vblank     = vb;
        vga_row        = vrow;
        vga_col        = vcol;
        @(posedge clk);
        #1;
    endtask

    task automatic writePix(input logic [8:0] r, input logic [8:0] c,
                            input logic [7:0] d);
        applyStimulus(1'b1, r, c, d, 1'b0, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic readPix(input logic [9:0] r, input logic [9:0] c);
        applyStimulus(1'b0, 9'd0, 9'd0, 8'd0, 1'b0, 1'b0, r, c);
    endtask

    task automatic pulseDone(input logic vb);
        applyStimulus(1'b0, 9'd0, 9'd0, 8'd0, 1'b1, vb, 10'd0, 10'd0);
    endtask

    task automatic raiseVblank();
        applyStimulus(1'b0, 9'd0, 9'd0, 8'd0, 1'b0, 1'b1, 10'd0, 10'd0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 9'd0, 9'd0, 8'd0, 1'b0, 1'b0, 10'd0, 10'd0);
    endtask

    // Bounded wait for the monitor to consume every queued expectation
    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", {7'd0, sb.size() == 0}, 8'd1);
    endtask

    initial begin
        // Reset values appear without any clock edge
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst0_vga_data", vga_data, 8'h3F);
        checkOutput("rst0_front_sel", {7'd0, front_sel}, 8'd0);
        checkOutput("rst0_swap_pending", {7'd0, swap_pending}, 8'd0);
        checkOutput("rst0_drop_count", drop_count, 8'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle();

        // Fill the back bank (bank 1), then swap it to the front
        writePix(9'd10, 9'd20, 8'h15);
        writePix(9'd0, 9'd0, 8'h5A);
        writePix(9'd0, 9'd1, 8'h77);
        expectNext("done_sets_pending", SIG_PEND, 8'd1);
        expectNext("done_no_toggle", SIG_FRONT, 8'd0);
        pulseDone(1'b0);
        expectNext("vblank_toggles_front", SIG_FRONT, 8'd1);
        expectNext("vblank_clears_pending", SIG_PEND, 8'd0);
        raiseVblank();

        // Reads back to back, each expected one cycle later
`ifdef FB_SCALE2X_EN
        expectNext("read_10_20", SIG_DATA, 8'h15);
        readPix(10'd20, 10'd104);
        expectNext("s2x_0_0", SIG_DATA, 8'h5A);
        readPix(10'd0, 10'd64);
        expectNext("s2x_0_1", SIG_DATA, 8'h5A);
        readPix(10'd0, 10'd65);
        expectNext("s2x_1_0", SIG_DATA, 8'h5A);
        readPix(10'd1, 10'd64);
        expectNext("s2x_1_1", SIG_DATA, 8'h5A);
        readPix(10'd1, 10'd65);
        expectNext("s2x_0_2", SIG_DATA, 8'h77);
        readPix(10'd0, 10'd66);
        expectNext("s2x_row480_blank", SIG_DATA, 8'h3F);
        readPix(10'd480, 10'd64);
        expectNext("s2x_col576_blank", SIG_DATA, 8'h3F);
        readPix(10'd0, 10'd576);
`else
        expectNext("read_10_20", SIG_DATA, 8'h15);
        readPix(10'd10, 10'd84);
        expectNext("win_origin", SIG_DATA, 8'h5A);
        readPix(10'd0, 10'd64);
        expectNext("win_col65", SIG_DATA, 8'h77);
        readPix(10'd0, 10'd65);
        expectNext("win_row240_blank", SIG_DATA, 8'h3F);
        readPix(10'd240, 10'd64);
        expectNext("win_col320_blank", SIG_DATA, 8'h3F);
        readPix(10'd0, 10'd320);
`endif
        expectNext("win_col63_blank", SIG_DATA, 8'h3F);
        readPix(10'd0, 10'd63);
        expectNext("win_479_639_blank", SIG_DATA, 8'h3F);
        readPix(10'd479, 10'd639);

        // Range guard: the back bank is now bank 0
        writePix(9'd0, 9'd0, 8'h33);
        writePix(9'd240, 9'd0, 8'hAA);
        writePix(9'd0, 9'd256, 8'hAA);
        expectNext("guard_front_intact", SIG_DATA, 8'h5A);
        readPix(10'd0, 10'd64);
        expectNext("guard_pending", SIG_PEND, 8'd1);
        pulseDone(1'b0);
        expectNext("guard_swap_front0", SIG_FRONT, 8'd0);
        raiseVblank();
        expectNext("guard_prior_value", SIG_DATA, 8'h33);
        readPix(10'd0, 10'd64);

        // Dropped frame, plus a write while PENDING into the back bank (bank 1)
        expectNext("drop_first_pending", SIG_PEND, 8'd1);
        pulseDone(1'b0);
        idle();
        expectNext("drop_count_1", SIG_DROP, 8'd1);
        expectNext("drop_still_pending", SIG_PEND, 8'd1);
        pulseDone(1'b0);
        writePix(9'd0, 9'd0, 8'h44);
        expectNext("drop_single_toggle", SIG_FRONT, 8'd1);
        expectNext("drop_swap_clears", SIG_PEND, 8'd0);
        raiseVblank();
        expectNext("pending_write_shown", SIG_DATA, 8'h44);
        readPix(10'd0, 10'd64);
        expectNext("no_second_toggle", SIG_FRONT, 8'd1);
        idle();

        // frame_done together with vblank while PENDING: swap, no drop
        expectNext("coinc_pending", SIG_PEND, 8'd1);
        pulseDone(1'b0);
        expectNext("coinc_toggle", SIG_FRONT, 8'd0);
        expectNext("coinc_no_drop", SIG_DROP, 8'd1);
        pulseDone(1'b1);
        expectNext("coinc_done_lost", SIG_PEND, 8'd0);
        idle();

        // 300 frame_done pulses without vblank saturate the drop counter
        for (int i = 0; i < 300; i++) begin
            if (i == 253) expectNext("drop_count_254", SIG_DROP, 8'd254);
            if (i == 299) begin
                expectNext("drop_saturated", SIG_DROP, 8'd255);
                expectNext("sat_pending", SIG_PEND, 8'd1);
            end
            pulseDone(1'b0);
        end

        // Build a busy state, then reset it mid-operation
        expectNext("pre_rst_toggle", SIG_FRONT, 8'd1);
        raiseVblank();
        expectNext("pre_rst_pending", SIG_PEND, 8'd1);
        pulseDone(1'b0);
        expectNext("pre_rst_pixel", SIG_DATA, 8'h44);
        readPix(10'd0, 10'd64);
        drain();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_vga_data", vga_data, 8'h3F);
        checkOutput("rst_mid_front_sel", {7'd0, front_sel}, 8'd0);
        checkOutput("rst_mid_swap_pending", {7'd0, swap_pending}, 8'd0);
        checkOutput("rst_mid_drop_count", drop_count, 8'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vga_frame_buffer_db.md
Name: vga_frame_buffer_db

Overview:
Parametrised, double-buffered frame buffer between the PPU pixel writer and the VGA scan-out.
- PPU writes always go to the back bank; VGA reads always come from the front bank.
- Banks swap only during VGA vertical blanking, after the PPU signals frame completion. This removes tearing.
- Adds a positionable display window, a 1-cycle registered read path and dropped-frame accounting.

Parameters:
FB_WIDTH, 256, active pixels per line.
FB_HEIGHT, 240, active lines per frame.
PIX_W, 8, bits per pixel (palette index).
BLANK_PIX, 8'h3F, value output outside the window (PIX_W bits; 0x3F = NES black).
H_OFFSET, 0, first VGA column of the window.
V_OFFSET, 0, first VGA row of the window.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous, active-low.
ppu_row  in  9  PPU write row.
ppu_col  in  9  PPU write column.
ppu_data  in  PIX_W  PPU write pixel.
ppu_write_en  in  1  write strobe.
ppu_frame_done  in  1  1-cycle pulse: PPU finished a frame.
vga_row  in  10  VGA scan row.
vga_col  in  10  VGA scan column.
vga_vblank  in  1  level, high during VGA vertical blanking.
vga_data  out  PIX_W  pixel for the VGA coordinates of the previous cycle.
swap_pending  out  1  a completed frame is waiting for vblank.
front_sel  out  1  bank currently displayed.
drop_count  out  8  saturating count of frames overwritten before display.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Storage: two banks of FB_WIDTH*FB_HEIGHT words of PIX_W bits. Address = row*FB_WIDTH + col, width $clog2(FB_WIDTH*FB_HEIGHT).
- RAM contents are not reset.
- Values on reset: vga_data=BLANK_PIX, front_sel=0, swap_pending=0, drop_count=0, FSM=IDLE.
- Write path:
  - Write occurs on the clk edge when ppu_write_en=1, ppu_row<FB_HEIGHT and ppu_col<FB_WIDTH.
  - Target is bank ~front_sel, using the front_sel value in that cycle.
  - Out-of-range writes are discarded. No write to address 0.
- Read path:
  - Window condition: vga_row in [V_OFFSET, V_OFFSET+FB_HEIGHT) and vga_col in [H_OFFSET, H_OFFSET+FB_WIDTH).
  - Local coordinates are (vga_row-V_OFFSET, vga_col-H_OFFSET).
  - Read from bank front_sel, using the front_sel value in the sampling cycle.
  - Latency is exactly 1 cycle. The in-window flag is pipelined alongside the data; out-of-window gives vga_data=BLANK_PIX.
- Swap FSM:
  - IDLE: ppu_frame_done=1 -> PENDING, swap_pending=1 on the next edge. vga_vblank is not checked on the entry cycle.
  - PENDING with vga_vblank=1 at the edge: front_sel toggles, swap_pending clears, -> IDLE, all on the same edge.
  - PENDING with ppu_frame_done=1 and vga_vblank=0: drop_count+1, saturating at 255; stay PENDING.
  - PENDING with ppu_frame_done=1 and vga_vblank=1 in the same cycle: swap happens -> IDLE, no drop is counted and the new done is lost. Mark this as a documented limitation.
  - PPU writes during PENDING still target the current back bank. After the swap, writes go to the new back bank.
- Reset mid-operation: outputs return to their reset values immediately (async reset). A pending swap is abandoned.

Optional Feature:
Macro: FB_SCALE2X_EN.
- Defined:
  - Window becomes 2*FB_WIDTH x 2*FB_HEIGHT starting at (V_OFFSET, H_OFFSET).
  - Local coordinates are shifted right by 1 (pixel doubling). For example, 256x240 fills 512x480.
- Undefined: 1:1 mapping as described in Behaviour.
- Latency is 1 cycle in both cases.

Test Plan:
- Reset: assert rst_n=0 mid-frame -> vga_data=0x3F, front_sel=0, swap_pending=0, drop_count=0 with no clock edge needed.
- Write/swap/read: write 0x15 at PPU (10,20) into bank 1, pulse frame_done, raise vblank -> front_sel=1 and swap_pending=0 on the same edge. Then present VGA (10,20) -> vga_data=0x15 one cycle later.
- Range guard: write 0xAA with ppu_row=240, then swap -> VGA (0,0) still shows its prior value and no bank changes.
- Dropped frames: two frame_done pulses with vblank=0 -> swap_pending=1, drop_count=1. Then vblank -> exactly one toggle. Pulse 300 frame_done without vblank -> drop_count=255.
- Window: H_OFFSET=64 with VGA (0,63) -> 0x3F; VGA (0,64) -> bank pixel (0,0). VGA (479,639) -> 0x3F.
- FB_SCALE2X_EN: VGA (0,0), (0,1), (1,0) and (1,1) all return pixel (0,0). VGA (0,2) returns pixel (0,1). VGA (480,0) -> 0x3F.
